// File: rtl/huff_bit_chunker.sv
// Bitstream chunker ahead of the Huffman decoder's shift stage: takes WORD_W-bit
// words over valid/ready and emits MSB-first chunks of up to CHUNK_W bits.
module huff_bit_chunker #(
  parameter int WORD_W  = 16,
  parameter int CHUNK_W = 4,
  parameter int NB_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              word_last,
  input  logic [NB_W-1:0]   last_nbits,
  output logic [3:0]        out_bits,
  output logic [2:0]        out_len,
  output logic              out_valid,
  input  logic              aready,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       chunk_count
);

  localparam int RW = $clog2(WORD_W + 1);
  localparam logic [RW-1:0] CW = RW'(CHUNK_W);
  localparam logic [RW-1:0] WW = RW'(WORD_W);

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t            r_state, w_state_nx;
  logic [WORD_W-1:0] r_word, w_word_nx;
  logic [RW-1:0]     r_rem, w_rem_nx;
  logic              r_last, w_last_nx;
  logic [RW-1:0]     w_len, w_len_nx;
  logic              w_xfer, w_acc, w_hold_nx;
  logic [CHUNK_W-1:0] w_top;
  logic [3:0]        w_bits_nx;

  assign w_len = (r_rem < CW) ? r_rem : CW;
  assign busy  = (r_state == S_HOLD);

  always_comb begin
    w_state_nx = r_state;
    w_word_nx  = r_word;
    w_rem_nx   = r_rem;
    w_last_nx  = r_last;
    w_xfer     = (r_state == S_HOLD) & aready;
    word_ready = (r_state == S_EMPTY) | (w_xfer & (r_rem <= CW));
    w_acc      = word_valid & word_ready;
    if (w_xfer) begin
      w_word_nx = r_word << w_len;
      w_rem_nx  = r_rem - w_len;
      if (r_rem == w_len) w_state_nx = S_EMPTY;
    end
    // A new word overrides the final-chunk drain so there is no bubble.
    if (w_acc) begin
      w_state_nx = S_HOLD;
      w_word_nx  = word_in;
      w_last_nx  = word_last;
      w_rem_nx   = WW;
      if (word_last && (last_nbits != '0) && (last_nbits <= NB_W'(WORD_W)))
        w_rem_nx = RW'(last_nbits);
    end
    w_hold_nx = (w_state_nx == S_HOLD);
    w_len_nx  = (w_rem_nx < CW) ? w_rem_nx : CW;
    w_top     = w_word_nx[WORD_W-1 -: CHUNK_W];
    w_bits_nx = 4'(w_top >> (CW - w_len_nx));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_word      <= '0;
      r_rem       <= '0;
      r_last      <= 1'b0;
      out_valid   <= 1'b0;
      out_bits    <= '0;
      out_len     <= '0;
      out_last    <= 1'b0;
      chunk_count <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_word      <= w_word_nx;
      r_rem       <= w_rem_nx;
      r_last      <= w_last_nx;
      out_valid   <= w_hold_nx;
      out_bits    <= w_hold_nx ? w_bits_nx : 4'd0;
      out_len     <= w_hold_nx ? 3'(w_len_nx) : 3'd0;
      out_last    <= w_hold_nx & w_last_nx & (w_rem_nx <= CW);
      chunk_count <= chunk_count + 16'(w_xfer);
    end
  end

endmodule
